// File: rtl/prio_encoder_7seg.sv
// Debounced N-input priority encoder driving a single active-low 7-segment digit.
// Adds a hold (freeze) input and a one-cycle pulse whenever {valid,code} changes.
module prio_encoder_7seg #(
  parameter int unsigned N            = 8,
  parameter int unsigned DEB_CYCLES   = 4,
  parameter int unsigned MSB_PRIORITY = 1,
  localparam int unsigned W           = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in,
  input  logic         hold,
  output logic [W-1:0] code,
  output logic         valid,
  output logic         changed,
  output logic [6:0]   seg
);

  // A one-bit counter still exists when DEB_CYCLES is 1; it simply never counts.
  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CntMax = CW'(DEB_CYCLES - 1);
  localparam logic [6:0] SegDash = 7'b0111111;

  logic [N-1:0]         s1_q, s1_d;
  logic [N-1:0]         s2_q, s2_d;
  logic [N-1:0]         deb_q, deb_d;
  logic [N-1:0][CW-1:0] cnt_q, cnt_d;

  logic [W-1:0] enc_code;
  logic         enc_valid;
  logic [3:0]   glyph_idx;
  logic [6:0]   glyph;

  logic [W-1:0] code_q, code_d;
  logic         valid_q, valid_d;
  logic         changed_q, changed_d;
  logic [6:0]   seg_q, seg_d;

  // Synchroniser and debouncer next state
  always_comb begin
    s1_d  = in;
    s2_d  = s1_q;
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < int'(N); i++) begin
      if (s2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        deb_d[i] = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // The last matching index in scan order wins, so scan direction sets priority.
  always_comb begin
    enc_code  = '0;
    enc_valid = |deb_q;
    for (int i = 0; i < int'(N); i++) begin
      if (MSB_PRIORITY != 0) begin
        if (deb_q[i]) enc_code = W'(i);
      end else begin
        if (deb_q[int'(N) - 1 - i]) enc_code = W'(int'(N) - 1 - i);
      end
    end
  end

  always_comb begin
    glyph_idx = 4'(enc_code);
    glyph     = SegDash;
    if (enc_valid) begin
      unique case (glyph_idx)
        4'h0: glyph = 7'b1000000;
        4'h1: glyph = 7'b1111001;
        4'h2: glyph = 7'b0100100;
        4'h3: glyph = 7'b0110000;
        4'h4: glyph = 7'b0011001;
        4'h5: glyph = 7'b0010010;
        4'h6: glyph = 7'b0000010;
        4'h7: glyph = 7'b1111000;
        4'h8: glyph = 7'b0000000;
        4'h9: glyph = 7'b0010000;
        4'hA: glyph = 7'b0001000;
        4'hB: glyph = 7'b0000011;
        4'hC: glyph = 7'b1000110;
        4'hD: glyph = 7'b0100001;
        4'hE: glyph = 7'b0000110;
        4'hF: glyph = 7'b0001110;
        default: glyph = SegDash;
      endcase
    end
  end

  always_comb begin
    code_d    = code_q;
    valid_d   = valid_q;
    seg_d     = seg_q;
    changed_d = 1'b0;
    if (!hold) begin
      code_d    = enc_code;
      valid_d   = enc_valid;
      seg_d     = glyph;
      changed_d = ({enc_valid, enc_code} != {valid_q, code_q});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      deb_q     <= '0;
      cnt_q     <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      seg_q     <= SegDash;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      deb_q     <= deb_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
      seg_q     <= seg_d;
    end
  end

  assign code    = code_q;
  assign valid   = valid_q;
  assign changed = changed_q;
  assign seg     = seg_q;

endmodule

// File: tb/tb_prio_encoder_7seg.sv
// Scoreboard bench for four prio_encoder_7seg configurations sharing one random input bus.
// A level-stability reference model predicts every output cycle; a monitor pops and compares.
module tb_prio_encoder_7seg;

  localparam int NI = 4;

  typedef struct packed {
    logic [3:0] code;
    logic       valid;
    logic       changed;
    logic [6:0] seg;
  } exp_t;
  typedef exp_t [NI-1:0] row_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold;
  logic [15:0] rin;

  logic [2:0] code_a;
  logic [2:0] code_b;
  logic [3:0] code_c;
  logic [0:0] code_d;
  logic       valid_a, valid_b, valid_c, valid_d;
  logic       changed_a, changed_b, changed_c, changed_d;
  logic [6:0] seg_a, seg_b, seg_c, seg_d;

  int nvec = 0;
  int nmis = 0;

  row_t        q [$];
  logic [15:0] hist [$];
  logic [15:0] md [NI];
  exp_t        mo [NI];

  always #5 clk = ~clk;

  prio_encoder_7seg #(.N(8), .DEB_CYCLES(4), .MSB_PRIORITY(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in(rin[7:0]), .hold(hold),
    .code(code_a), .valid(valid_a), .changed(changed_a), .seg(seg_a)
  );
  prio_encoder_7seg #(.N(8), .DEB_CYCLES(4), .MSB_PRIORITY(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in(rin[7:0]), .hold(hold),
    .code(code_b), .valid(valid_b), .changed(changed_b), .seg(seg_b)
  );
  prio_encoder_7seg #(.N(16), .DEB_CYCLES(3), .MSB_PRIORITY(1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .in(rin), .hold(hold),
    .code(code_c), .valid(valid_c), .changed(changed_c), .seg(seg_c)
  );
  prio_encoder_7seg #(.N(2), .DEB_CYCLES(1), .MSB_PRIORITY(0)) u_dut_d (
    .clk(clk), .rst_n(rst_n), .in(rin[1:0]), .hold(hold),
    .code(code_d), .valid(valid_d), .changed(changed_d), .seg(seg_d)
  );

  function automatic int inst_n(int i);
    case (i)
      2:       return 16;
      3:       return 2;
      default: return 8;
    endcase
  endfunction

  function automatic int inst_deb(int i);
    case (i)
      2:       return 3;
      3:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic bit inst_msb(int i);
    return (i == 0) || (i == 2);
  endfunction

  function automatic logic [6:0] glyph(logic [3:0] c);
    case (c)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic exp_t reset_exp();
    exp_t r;
    r.code    = 4'h0;
    r.valid   = 1'b0;
    r.changed = 1'b0;
    r.seg     = 7'b0111111;
    return r;
  endfunction

  // Winner by arithmetic: floor(log2(v)) for MSB-first, log2 of the isolated low bit otherwise.
  function automatic exp_t enc_model(int i, logic [15:0] dv);
    int unsigned v, sel;
    exp_t r;
    r = reset_exp();
    v = 32'(dv) & ((32'd1 << inst_n(i)) - 32'd1);
    if (v != 0) begin
      sel     = inst_msb(i) ? v : (v & (~v + 32'd1));
      r.code  = 4'($clog2(sel + 32'd1) - 1);
      r.valid = 1'b1;
      r.seg   = glyph(r.code);
    end
    return r;
  endfunction

  function automatic exp_t actual(int i);
    exp_t r;
    case (i)
      0: r = '{code: {1'b0, code_a}, valid: valid_a, changed: changed_a, seg: seg_a};
      1: r = '{code: {1'b0, code_b}, valid: valid_b, changed: changed_b, seg: seg_b};
      2: r = '{code: code_c, valid: valid_c, changed: changed_c, seg: seg_c};
      default: r = '{code: {3'b000, code_d}, valid: valid_d, changed: changed_d, seg: seg_d};
    endcase
    return r;
  endfunction

  task automatic check(input int i, input exp_t e, input string tag);
    exp_t a;
    a = actual(i);
    nvec++;
    if (a !== e) begin
      nmis++;
      $display("FAIL %s inst%0d t=%0t: got code=%h valid=%b changed=%b seg=%b, want code=%h valid=%b changed=%b seg=%b",
               tag, i, $time, a.code, a.valid, a.changed, a.seg,
               e.code, e.valid, e.changed, e.seg);
    end
  endtask

  // Reference model: a bit's debounced level flips once its sampled value
  // has been stable and different for DEB consecutive synchronised samples.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        hist.delete();
        q.delete();
        for (int i = 0; i < NI; i++) begin
          md[i] = '0;
          mo[i] = reset_exp();
        end
      end else begin
        row_t row;
        for (int i = 0; i < NI; i++) begin
          exp_t nx;
          if (hold) begin
            nx         = mo[i];
            nx.changed = 1'b0;
          end else begin
            nx         = enc_model(i, md[i]);
            nx.changed = ({nx.valid, nx.code} != {mo[i].valid, mo[i].code});
          end
          mo[i]  = nx;
          row[i] = nx;
        end
        q.push_back(row);
        if (hist.size() >= 2) begin
          for (int b = 0; b < 16; b++) begin
            logic x;
            int   run;
            x   = hist[1][b];
            run = 0;
            for (int j = 1; j < hist.size(); j++) begin
              if (hist[j][b] != x) break;
              run++;
            end
            for (int i = 0; i < NI; i++)
              if (md[i][b] != x && run >= inst_deb(i)) md[i][b] = x;
          end
        end
        hist.push_front(rin);
        if (hist.size() > 24) void'(hist.pop_back());
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (q.size() == 0) begin
          nvec++;
          nmis++;
          $display("FAIL scoreboard t=%0t: got empty queue, want one expected row", $time);
        end else begin
          row_t row;
          row = q.pop_front();
          for (int i = 0; i < NI; i++) check(i, row[i], "cycle");
        end
      end
    end
  end

  task automatic drive(input logic [15:0] v, input logic h, input int n);
    rin  = v;
    hold = h;
    repeat (n) @(negedge clk);
  endtask

  task automatic rand_phase(input int n);
    for (int k = 0; k < n; k++) begin
      logic [15:0] v;
      v = 16'($urandom);
      if ($urandom_range(0, 1) == 0) v = v & 16'($urandom);
      drive(v, ($urandom_range(0, 5) == 0), $urandom_range(1, 7));
    end
  endtask

  initial begin
    rin   = '0;
    hold  = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) check(i, reset_exp(), "reset");
    rst_n = 1'b1;

    drive(16'h0000, 1'b0, 6);
    drive(16'h0024, 1'b0, 10);
    drive(16'h0004, 1'b0, 8);
    drive(16'h0084, 1'b0, 3);
    drive(16'h0004, 1'b0, 8);
    drive(16'h0084, 1'b0, 8);
    drive(16'h0090, 1'b0, 8);
    drive(16'h0091, 1'b0, 8);
    drive(16'h0000, 1'b0, 8);
    drive(16'h0008, 1'b0, 8);
    drive(16'h0048, 1'b1, 10);
    drive(16'h0048, 1'b0, 4);
    drive(16'h0048, 1'b1, 3);
    drive(16'h0048, 1'b0, 3);
    drive(16'h8000, 1'b0, 8);
    drive(16'h0002, 1'b0, 8);

    rand_phase(1200);

    drive(16'hFFFF, 1'b0, 2);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) check(i, reset_exp(), "midreset");
    @(negedge clk);
    rst_n = 1'b1;
    drive(16'hFFFF, 1'b0, 10);

    rand_phase(200);
    drive(16'h0000, 1'b0, 10);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/prio_encoder_7seg.md
# prio_encoder_7seg

Parametrised, clocked successor to the combinational 4-to-2 decoder/display path. It takes N raw switch/button inputs, synchronises and debounces each one, and priority-encodes the debounced vector into a binary index with a valid flag. It drives the index directly onto a 7-segment digit. It also adds a hold (freeze) mode and a one-cycle change-notification pulse, for use by downstream FSMs on the board.

## Interface
- N, default 8: number of input lines; legal range 2..16.
- DEB_CYCLES, default 4: consecutive stable samples required to accept a new level; must be ≥1.
- MSB_PRIORITY, default 1:
  - 1: highest set index wins.
  - 0: lowest set index wins.
- W, derived: $clog2(N); not overridable.

- clk  in  1  single system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in  in  N  raw asynchronous inputs (switches/buttons), active-high.
- hold  in  1  synchronous; 1 freezes code/valid/seg.
- code  out  W  encoded index of winning debounced input.
- valid  out  1  1 when any debounced input is high.
- changed  out  1  one-cycle pulse when {valid,code} takes a new value.
- seg  out  7  active-low segments, seg[0]=a … seg[6]=g; hex glyph of code, or dash when !valid.

## Operation
- **Per-bit synchroniser:** two flops, s1 then s2, reset to 0.
- **Per-bit debouncer:** debounced bit d (reset 0) plus counter cnt, sized for 0..DEB_CYCLES-1 (reset 0).
  - s2 == d: cnt cleared to 0.
  - s2 != d and cnt == DEB_CYCLES-1: d takes s2 and cnt clears.
  - Otherwise: cnt increments.
  - Result: any excursion shorter than DEB_CYCLES samples is discarded.
- **Encoder:** combinational on the debounced vector.
  - MSB_PRIORITY=1: code = index of the highest 1.
  - MSB_PRIORITY=0: code = index of the lowest 1.
  - All zero: valid=0, code=0.
- **Output register**, with hold=0:
  - code, valid and seg load every cycle from the encoder.
  - changed = 1 for exactly one cycle when the newly loaded {valid,code} differs from the currently held {valid,code}.
- **Output register**, with hold=1:
  - code, valid and seg keep their values; changed=0.
  - Synchronisers and debouncers keep running.
  - On the first edge with hold=0 the register loads the current encoding; changed pulses if it differs from the frozen value.
- **seg glyphs**, active-low, order g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - dash (!valid) = 0111111
- **Width rule:** code is zero-extended to 4 bits for glyph lookup. Indices ≥N cannot occur.

## Timing
- **Reset** (asynchronous assert, synchronous-safe deassert by design convention):
  - All s1/s2/d bits = 0, all cnt = 0.
  - code=0, valid=0, changed=0, seg=0111111 (dash).
- **Latency:** a clean input level first sampled into s1 at edge k:
  - reaches s2 at edge k+1;
  - reaches d at edge k+1+DEB_CYCLES;
  - reaches code/valid/seg/changed at edge k+2+DEB_CYCLES.
  - Default DEB_CYCLES=4 gives edge k+6.
- **Glitch rule:** a level lasting fewer than DEB_CYCLES s2 samples never reaches d. cnt restarts from 0 on any return to the d level.
- **Simultaneous events:**
  - Several bits settling on the same edge are encoded together; only one changed pulse is produced.
  - A priority change that leaves code identical (e.g. a lower bit rises while a higher bit is held, MSB mode) produces no pulse.
- **Hold:**
  - Sampled each edge; hold=1 on edge j freezes outputs at edge j.
  - Release at edge m updates outputs at edge m.
  - changed is never asserted while hold=1.
- **Back-to-back changes:** changed may be high on consecutive cycles if {valid,code} differs on each cycle.
- **Reset mid-debounce:** all partial counts are lost. After deassert, an input already high needs the full k+2+DEB_CYCLES path again.

## Test plan
- **Reset:** assert rst_n=0 mid-run with in=8'hFF → immediately code=0, valid=0, seg=0111111, changed=0.
- **Latency and encoding:** N=8, MSB_PRIORITY=1, in goes 0→8'b0010_0100 at edge k → at edge k+6: code=5, valid=1, seg=0010010, changed=1 for one cycle; nothing changes earlier.
- **Glitch rejection:** pulse in[7] high for 3 cycles while in[2] is stable high → code stays 2 and changed never pulses. Then hold in[7] for 4+ cycles → code=7 with a single changed pulse.
- **Lowest-first priority:** MSB_PRIORITY=0, in=8'b1001_0000 → code=4. Add in[0] → code=0. Drop all inputs → valid=0, code=0, dash, one changed pulse per transition.
- **Hold:** set hold=1 with code=3, then change inputs to encode 6 → outputs stay 3 with no pulse. Release hold → code=6 on the release edge with one changed pulse. Release with unchanged encoding → no pulse.
- **Width generality:** N=16, set in[15] only → code=4'hF, seg=0001110. N=2, set in[1] → code=1, seg=1111001.
